// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment capture block.
//   - glyph constants for the active-low segment patterns of hex digits 0..F
//     (bit0 = segment a ... bit6 = segment g) plus the all-off blank pattern
//   - default number of multiplexed digit positions
//   - capture FSM state encoding
package seven_seg_pkg;

  localparam int DIGITS_DEFAULT = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    COMMIT = 2'd2,
    HELD   = 2'd3
  } cap_state_e;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational decoder from an active-low seven-segment pattern to a hex
// nibble.
// Ports:
//   seg    - active-low segment pattern, bit0 = a ... bit6 = g
//   nibble - decoded hex value (0 when the pattern is not a hex glyph)
//   legal  - pattern is one of the sixteen hex glyphs
//   blank  - pattern has every segment off
module seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    blank  = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures the digits shown on a multiplexed seven-segment display by
// snooping its segment and anode drives. A digit is committed once its
// (anode, segment) sample has been stable for STABLE_CYCLES consecutive
// cycles; each uninterrupted dwell commits exactly once.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   seg_in      - active-low segment pattern, bit0 = a ... bit6 = g
//   an_in       - active-low digit select, one bit per digit position
//   value_out   - decoded nibble per digit, digit d in bits [4d+3:4d]
//   valid_out   - per digit: last commit was a legal hex glyph
//   err_out     - per digit: last commit was an illegal pattern
//   upd_out     - single-cycle pulse on each commit
//   upd_digit   - digit index of the commit, meaningful while upd_out = 1
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int DIGITS        = DIGITS_DEFAULT,
  parameter int STABLE_CYCLES = 4,
  localparam int DW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [DIGITS-1:0]     valid_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  upd_out,
  output logic [DW-1:0]         upd_digit
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  cap_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     ref_an_q, ref_an_d;
  logic [6:0]            ref_seg_q, ref_seg_d;
  logic [4*DIGITS-1:0]   value_q, value_d;
  logic [DIGITS-1:0]     valid_q, valid_d;
  logic [DIGITS-1:0]     err_q, err_d;
  logic                  upd_q, upd_d;
  logic [DW-1:0]         upd_digit_q, upd_digit_d;

  logic [7:0]            low_cnt;
  logic                  sample_sel;
  logic                  sample_same;
  logic [DW-1:0]         commit_idx;
  logic                  commit;
  logic [3:0]            glyph_nibble;
  logic                  glyph_legal;
  logic                  glyph_blank;

  // The commit always acts on the reference sample, which is the one that
  // was counted stable, so the decoder looks at that rather than the live one.
  seg_glyph_decode u_decode (
    .seg    (ref_seg_q),
    .nibble (glyph_nibble),
    .legal  (glyph_legal),
    .blank  (glyph_blank)
  );

  assign an_d  = an_in;
  assign seg_d = seg_in;

  // Classify the registered sample and locate the digit of the reference.
  always_comb begin
    low_cnt    = 8'd0;
    commit_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) begin
        low_cnt = low_cnt + 8'd1;
      end
      if (!ref_an_q[i]) begin
        commit_idx = DW'(i);
      end
    end
    sample_sel  = (low_cnt == 8'd1);
    sample_same = (an_q == ref_an_q) && (seg_q == ref_seg_q);
  end

  // Stability FSM. Any change of sample while counting or holding restarts
  // the dwell; the COMMIT cycle itself does not look at the sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_an_d  = ref_an_q;
    ref_seg_d = ref_seg_q;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_sel) begin
          state_d   = COUNT;
          cnt_d     = 8'd1;
          ref_an_d  = an_q;
          ref_seg_d = seg_q;
        end
      end
      COUNT: begin
        if (sample_same) begin
          if (cnt_q >= STABLE_C - 8'd1) begin
            cnt_d   = STABLE_C;
            state_d = COMMIT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (sample_sel) begin
          cnt_d     = 8'd1;
          ref_an_d  = an_q;
          ref_seg_d = seg_q;
        end else begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = HELD;
      end
      HELD: begin
        if (!sample_same) begin
          if (sample_sel) begin
            state_d   = COUNT;
            cnt_d     = 8'd1;
            ref_an_d  = an_q;
            ref_seg_d = seg_q;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Commit effect on the selected digit; every other digit keeps its state.
  always_comb begin
    value_d     = value_q;
    valid_d     = valid_q;
    err_d       = err_q;
    upd_d       = 1'b0;
    upd_digit_d = upd_digit_q;
    if (commit) begin
      upd_d       = 1'b1;
      upd_digit_d = commit_idx;
      for (int d = 0; d < DIGITS; d++) begin
        if (DW'(d) == commit_idx) begin
          if (glyph_legal) begin
            value_d[4*d +: 4] = glyph_nibble;
            valid_d[d]        = 1'b1;
            err_d[d]          = 1'b0;
          end else if (glyph_blank) begin
            value_d[4*d +: 4] = 4'h0;
            valid_d[d]        = 1'b0;
            err_d[d]          = 1'b0;
          end else begin
            valid_d[d] = 1'b0;
            err_d[d]   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      an_q        <= '0;
      seg_q       <= '0;
      ref_an_q    <= '0;
      ref_seg_q   <= '0;
      value_q     <= '0;
      valid_q     <= '0;
      err_q       <= '0;
      upd_q       <= 1'b0;
      upd_digit_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      ref_an_q    <= ref_an_d;
      ref_seg_q   <= ref_seg_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      upd_q       <= upd_d;
      upd_digit_q <= upd_digit_d;
    end
  end

  assign value_out = value_q;
  assign valid_out = valid_q;
  assign err_out   = err_q;
  assign upd_out   = upd_q;
  assign upd_digit = upd_digit_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture (DIGITS = 4, STABLE_CYCLES = 4).
// A run-length reference model tracks how long the sampled (anode, segment)
// pair has been stable and predicts every output on every cycle; directed
// scenarios add literal expectations on top of it.
module tb_seven_seg_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in  = 4'hF;
  logic [15:0] value_out;
  logic [3:0]  valid_out;
  logic [3:0]  err_out;
  logic        upd_out;
  logic [1:0]  upd_digit;

  always #5 clk = ~clk;

  seven_seg_capture #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .an_in     (an_in),
    .value_out (value_out),
    .valid_out (valid_out),
    .err_out   (err_out),
    .upd_out   (upd_out),
    .upd_digit (upd_digit)
  );

  int total_checks = 0;
  int bad_checks   = 0;
  int dut_pulses   = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    an_in  = an;
    seg_in = seg;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model state: the run currently being timed, and the commit
  // events waiting to appear on the outputs (two edges after the decision).
  logic [3:0]  m_an    = '0;
  logic [6:0]  m_seg   = '0;
  int          m_cnt   = 0;
  bit          m_done  = 1'b0;
  bit          m_blind = 1'b0;
  logic [15:0] e_value = '0;
  logic [3:0]  e_valid = '0;
  logic [3:0]  e_err   = '0;
  bit          e_upd   = 1'b0;
  logic [1:0]  e_digit = '0;
  bit          p0_v = 1'b0, p1_v = 1'b0;
  logic [1:0]  p0_d = '0,   p1_d = '0;
  logic [6:0]  p0_s = '0,   p1_s = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_an = '0; m_seg = '0; m_cnt = 0; m_done = 0; m_blind = 0;
      e_value = '0; e_valid = '0; e_err = '0; e_upd = 0; e_digit = '0;
      p0_v = 0; p1_v = 0;
    end else begin
      e_upd = p1_v;
      if (p1_v) begin
        int  nib;
        e_digit = p1_d;
        nib = -1;
        for (int g = 0; g < 16; g++) if (glyph_tab[g] == p1_s) nib = g;
        if (nib >= 0) begin
          e_value[4*p1_d +: 4] = 4'(nib);
          e_valid[p1_d] = 1'b1;
          e_err[p1_d]   = 1'b0;
        end else if (p1_s == 7'h7F) begin
          e_value[4*p1_d +: 4] = 4'h0;
          e_valid[p1_d] = 1'b0;
          e_err[p1_d]   = 1'b0;
        end else begin
          e_valid[p1_d] = 1'b0;
          e_err[p1_d]   = 1'b1;
        end
      end
      p1_v = p0_v; p1_d = p0_d; p1_s = p0_s;
      p0_v = 1'b0;
      if (m_blind) begin
        // The sample arriving during the commit cycle is not looked at.
        m_blind = 1'b0;
      end else if (an_in == m_an && seg_in == m_seg && m_cnt > 0) begin
        if (m_cnt < STABLE) m_cnt++;
        if (m_cnt == STABLE && !m_done) begin
          m_done  = 1'b1;
          m_blind = 1'b1;
          p0_v    = 1'b1;
          p0_s    = m_seg;
          for (int i = 0; i < DIGITS; i++) if (!m_an[i]) p0_d = 2'(i);
        end
      end else begin
        m_an   = an_in;
        m_seg  = seg_in;
        m_done = 1'b0;
        m_cnt  = ($countones(~an_in) == 1) ? 1 : 0;
      end
    end
    #1;
    checkOutput("value_out", 32'(value_out), 32'(e_value));
    checkOutput("valid_out", 32'(valid_out), 32'(e_valid));
    checkOutput("err_out",   32'(err_out),   32'(e_err));
    checkOutput("upd_out",   32'(upd_out),   32'(e_upd));
    if (e_upd || !rst_n) checkOutput("upd_digit", 32'(upd_digit), 32'(e_digit));
    if (upd_out) dut_pulses++;
  end

  initial begin
    int p_start;
    logic [3:0] an;
    logic [6:0] seg;

    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset value", 32'(value_out), 32'h0);
    checkOutput("reset flags", 32'({valid_out, err_out, upd_out, upd_digit}), 32'h0);
    rst_n = 1'b1;
    applyStimulus(4'hF, 7'h7F, 2);

    // Single digit 0 showing "3": pulse exactly STABLE+2 cycles after start.
    p_start = dut_pulses;
    applyStimulus(4'b1110, 7'b0110000, 5);
    checkOutput("latency early", 32'(upd_out), 32'h0);
    applyStimulus(4'b1110, 7'b0110000, 1);
    checkOutput("latency pulse", 32'({upd_out, upd_digit}), 32'h4);
    applyStimulus(4'b1110, 7'b0110000, 4);
    checkOutput("hold3 pulses", 32'(dut_pulses - p_start), 32'd1);
    checkOutput("hold3 nibble", 32'(value_out[3:0]), 32'h3);
    checkOutput("hold3 valid", 32'(valid_out), 32'b0001);
    applyStimulus(4'hF, 7'h7F, 3);

    // Scan 0x1A2F across the four digits with a blank cycle between them.
    p_start = dut_pulses;
    applyStimulus(4'b1110, 7'b0001110, 6); applyStimulus(4'hF, 7'h7F, 1);
    applyStimulus(4'b1101, 7'b0100100, 6); applyStimulus(4'hF, 7'h7F, 1);
    applyStimulus(4'b1011, 7'b0001000, 6); applyStimulus(4'hF, 7'h7F, 1);
    applyStimulus(4'b0111, 7'b1111001, 6); applyStimulus(4'hF, 7'h7F, 3);
    checkOutput("scan value", 32'(value_out), 32'h1A2F);
    checkOutput("scan valid", 32'(valid_out), 32'b1111);
    checkOutput("scan pulses", 32'(dut_pulses - p_start), 32'd4);

    // Illegal pattern on digit 1.
    applyStimulus(4'b1101, 7'b1010101, 6); applyStimulus(4'hF, 7'h7F, 3);
    checkOutput("illegal err", 32'(err_out), 32'b0010);
    checkOutput("illegal valid", 32'(valid_out), 32'b1101);
    checkOutput("illegal nibble", 32'(value_out[7:4]), 32'h2);

    // Multi-select and a glitched dwell: nothing may commit.
    p_start = dut_pulses;
    applyStimulus(4'b0110, 7'b0000000, 20);
    applyStimulus(4'b1011, 7'b0010010, 2);
    applyStimulus(4'b1011, 7'b0000000, 1);
    applyStimulus(4'b1011, 7'b0010010, 1);
    applyStimulus(4'hF, 7'h7F, 3);
    checkOutput("glitch pulses", 32'(dut_pulses - p_start), 32'd0);
    checkOutput("glitch value", 32'(value_out), 32'h1A2F);
    checkOutput("glitch flags", 32'({valid_out, err_out}), 32'hD2);

    // Reset during the COMMIT cycle of digit 2, then a clean dwell.
    p_start = dut_pulses;
    applyStimulus(4'b1011, 7'b1111000, 4);
    applyStimulus(4'hF, 7'h7F, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset value", 32'(value_out), 32'h0);
    checkOutput("midreset flags", 32'({valid_out, err_out, upd_out, upd_digit}), 32'h0);
    applyStimulus(4'hF, 7'h7F, 2);
    rst_n = 1'b1;
    applyStimulus(4'b1011, 7'b1111000, 4);
    applyStimulus(4'hF, 7'h7F, 3);
    checkOutput("postreset pulses", 32'(dut_pulses - p_start), 32'd1);
    checkOutput("postreset value", 32'(value_out), 32'h0700);
    checkOutput("postreset valid", 32'(valid_out), 32'b0100);

    // Long dwell commits once; blanking the digit commits once more.
    p_start = dut_pulses;
    applyStimulus(4'b1101, 7'b0010000, 1000);
    checkOutput("long nibble", 32'(value_out[7:4]), 32'h9);
    applyStimulus(4'b1101, 7'h7F, 5);
    applyStimulus(4'hF, 7'h7F, 3);
    checkOutput("long pulses", 32'(dut_pulses - p_start), 32'd2);
    checkOutput("blank digit", 32'({valid_out[1], err_out[1], value_out[7:4]}), 32'h0);

    // Randomized dwells with occasional resets, checked by the model.
    for (int n = 0; n < 400; n++) begin
      int kind;
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        applyStimulus(4'hF, 7'h7F, int'($urandom_range(1, 2)));
        rst_n = 1'b1;
      end
      kind = int'($urandom_range(0, 19));
      if (kind < 14) begin
        an = ~(4'b0001 << $urandom_range(0, 3));
      end else if (kind < 17) begin
        an = 4'hF;
      end else begin
        an = ~((4'b0001 << $urandom_range(0, 1)) | (4'b0100 << $urandom_range(0, 1)));
      end
      kind = int'($urandom_range(0, 19));
      if (kind < 10)      seg = glyph_tab[$urandom_range(0, 15)];
      else if (kind < 13) seg = 7'h7F;
      else                seg = 7'($urandom_range(0, 127));
      applyStimulus(an, seg, int'($urandom_range(1, 8)));
    end
    applyStimulus(4'hF, 7'h7F, 4);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digit positions captured.
REQ-002 Parameter STABLE_CYCLES, default 4, legal range 2..255: consecutive identical samples required before a commit.
REQ-003 clk  input  1  single clock; all inputs are synchronous to it.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 seg_in  input  7  active-low segment pattern; bit0=a ... bit6=g.
REQ-006 an_in  input  DIGITS  active-low digit select; the digit is the index of the single low bit.
REQ-007 value_out  output  4*DIGITS  decoded hex nibble per digit; digit d occupies bits [4d+3:4d].
REQ-008 valid_out  output  DIGITS  per-digit flag: last commit was a legal hex glyph.
REQ-009 err_out  output  DIGITS  per-digit flag: last commit was an illegal pattern.
REQ-010 upd_out  output  1  one-cycle pulse on each commit.
REQ-011 upd_digit  output  clog2(DIGITS)  index of the digit committed; meaningful only while upd_out=1.

Function
REQ-012 Decode table (seg_in -> nibble): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-013 Pattern 1111111 is "blank"; any other pattern not listed in REQ-012 is "illegal".
REQ-014 The sample (an_in, seg_in) is registered every cycle; all decisions use the registered sample.
REQ-015 Sample class:
  - SEL: exactly one an_in bit low.
  - NONE: all an_in bits high.
  - MULTI: more than one an_in bit low.
REQ-016 FSM states and transitions:
  - IDLE -> COUNT on a SEL sample; the counter loads 1.
  - COUNT, sample identical to the previous one: counter increments.
  - COUNT -> COMMIT when the counter reaches STABLE_CYCLES.
  - COMMIT -> HELD unconditionally after one cycle.
  - HELD stays in HELD while the sample is unchanged.
  - COUNT or HELD with any change in an_in or seg_in: go to COUNT with the counter at 1 if the new sample is SEL, else go to IDLE.
  - NONE or MULTI samples always lead to IDLE.
REQ-017 The commit occurs in the COMMIT cycle, and the outputs update on the following edge. Latency from the first of STABLE_CYCLES identical input cycles to upd_out=1 is STABLE_CYCLES+2 cycles.
REQ-018 Commit effect on digit d:
  - legal glyph: nibble written, valid=1, err=0.
  - blank: nibble=0, valid=0, err=0.
  - illegal: nibble held, valid=0, err=1.
REQ-019 Exactly one commit occurs per uninterrupted dwell, regardless of dwell length; a stable digit held indefinitely never re-commits.
REQ-020 Digits not being committed retain their value, valid, and err.
REQ-021 upd_out is high for exactly one cycle per commit, and upd_digit equals d in that same cycle.
REQ-022 The counter saturates at STABLE_CYCLES; there is no wrap-around.
REQ-023 A change on the exact cycle the counter would reach STABLE_CYCLES aborts the commit (no partial commit).

Reset
REQ-024 While rst_n=0, all outputs are zero: value_out=0, valid_out=0, err_out=0, upd_out=0, upd_digit=0. The FSM is in IDLE, and the counter and sample registers are 0.
REQ-025 Reset assertion mid-COUNT or mid-COMMIT discards the pending commit, with no upd_out pulse.
REQ-026 After deassertion, the first sample is taken on the next rising edge, and no commit occurs before STABLE_CYCLES+2 cycles.

Structure
REQ-027 Package seven_seg_pkg holds: the 16 glyph constants and SEG_BLANK, the default DIGITS, and the FSM state enum (IDLE, COUNT, COMMIT, HELD).
REQ-028 Combinational sub-module seg_glyph_decode maps seg_in to {nibble, legal, blank}; seven_seg_capture instantiates it once.
REQ-029 No other sub-modules.

Verification (STABLE_CYCLES=4, DIGITS=4)
REQ-030 Hold an_in=1110, seg_in=0110000 for 10 cycles. Required: one upd_out pulse with upd_digit=0, value_out[3:0]=3, valid_out=0001.
REQ-031 Scan 4 digits, 6 cycles each, with 1 blank cycle between digits, showing 0x1A2F (patterns F, 2, A, 1 on digits 0..3). Required: value_out=16'h1A2F, valid_out=1111, 4 pulses total.
REQ-032 Hold an_in=1101, seg_in=1010101 for 6 cycles. Required: err_out=0010, valid_out[1]=0, value_out[7:4] unchanged.
REQ-033 Hold an_in=0110 for 20 cycles, then apply a seg_in glitch on cycle 3 of a 4-cycle dwell. Required: zero pulses, outputs unchanged.
REQ-034 Assert rst_n=0 during the COMMIT cycle of digit 2. Required: no pulse, all outputs 0. A subsequent identical dwell of 4 cycles commits normally.
REQ-035 Hold one digit stable for 1000 cycles, then blank it (seg_in=1111111) for 5 cycles. Required: exactly two pulses total; the final state is valid=0, err=0, nibble=0.
